// File: rtl/counter_pkg.sv
// Shared types for the up/down counter: count modes and the one-shot FSM state.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'd0,
        MODE_SAT     = 2'd1,
        MODE_ONESHOT = 2'd2
    } mode_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

endpackage

// File: rtl/updown_counter_n_if.sv
// Counter interface: control inputs and status outputs of updown_counter_n.
// With CNT_COMPARE_EN defined, the interface also carries cmp_val / cmp_match.
interface updown_counter_n_if #(
    parameter int WIDTH   = 4,
    parameter int PRESC_W = 4
);
    import counter_pkg::*;

    logic               en;
    logic               chnge;
    mode_t              mode;
    logic [PRESC_W-1:0] presc;
    logic               load_en;
    logic [WIDTH-1:0]   load;
    logic [WIDTH-1:0]   count;
    logic               tc;
    logic               done;
`ifdef CNT_COMPARE_EN
    logic [WIDTH-1:0]   cmp_val;
    logic               cmp_match;

    modport master (
        output en, chnge, mode, presc, load_en, load, cmp_val,
        input  count, tc, done, cmp_match
    );

    modport slave (
        input  en, chnge, mode, presc, load_en, load, cmp_val,
        output count, tc, done, cmp_match
    );
`else
    modport master (
        output en, chnge, mode, presc, load_en, load,
        input  count, tc, done
    );

    modport slave (
        input  en, chnge, mode, presc, load_en, load,
        output count, tc, done
    );
`endif

endinterface

// File: rtl/counter_prescaler.sv
// Prescaler for the up/down counter: produces a tick every presc+1 enabled cycles.
// The count freezes while en is low; clr restarts the period.
module counter_prescaler #(
    parameter int PRESC_W = 4
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               en,
    input  logic               clr,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] presc_cnt;
    logic               hit;

    // A lowered divisor that leaves presc_cnt above presc ends the period
    // at once instead of running the counter all the way round.
    assign hit  = (presc_cnt >= presc);
    assign tick = en && !clr && hit;

    // Count enabled cycles, restarting after each tick or on clear.
    always_ff @(posedge CLK) begin
        if (reset) begin
            presc_cnt <= '0;
        end else if (clr) begin
            presc_cnt <= '0;
        end else if (en) begin
            if (hit) begin
                presc_cnt <= '0;
            end else begin
                presc_cnt <= presc_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/updown_counter_n.sv
// Parametrised up/down counter with prescaler, parallel load, terminal-count
// pulse and wrap / saturate / one-shot modes.
// Optional feature macro: CNT_COMPARE_EN (adds cmp_val / cmp_match).
//
// state   | meaning
// ST_RUN  | counting on prescaler ticks
// ST_DONE | one-shot finished, ticks ignored until load or reset
module updown_counter_n
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = 2**WIDTH - 1,
    parameter int PRESC_W = 4
) (
    input  logic              CLK,
    input  logic              reset,
    updown_counter_n_if.slave bus
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] count_q;
    logic             tc_q;
    state_t           state;
    logic             tick;

    logic [WIDTH-1:0] term_val;
    logic [WIDTH-1:0] stepped;
    logic [WIDTH-1:0] wrap_val;
    logic [WIDTH-1:0] load_val;
    logic             at_term;

    counter_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .CLK   (CLK),
        .reset (reset),
        .en    (bus.en),
        .clr   (bus.load_en),
        .presc (bus.presc),
        .tick  (tick)
    );

    // Next-value candidates for the current direction.
    always_comb begin
        term_val = bus.chnge ? MAX_V : '0;
        at_term  = (count_q == term_val);
        stepped  = bus.chnge ? (count_q + 1'b1) : (count_q - 1'b1);
        wrap_val = bus.chnge ? '0 : MAX_V;
        load_val = (bus.load > MAX_V) ? MAX_V : bus.load;
    end

    // Count, terminal-count pulse and one-shot FSM; reset > load > step.
    always_ff @(posedge CLK) begin
        if (reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            state   <= ST_RUN;
        end else if (bus.load_en) begin
            count_q <= load_val;
            tc_q    <= 1'b0;
            state   <= ST_RUN;
        end else begin
            tc_q <= 1'b0;
            if (tick && state == ST_RUN) begin
                if (!at_term) begin
                    count_q <= stepped;
                    if (stepped == term_val) begin
                        tc_q <= 1'b1;
                        if (bus.mode == MODE_ONESHOT) begin
                            state <= ST_DONE;
                        end
                    end
                end else begin
                    // Already sitting on the terminal value: no new tc pulse.
                    case (bus.mode)
                        MODE_WRAP:    count_q <= wrap_val;
                        MODE_ONESHOT: state   <= ST_DONE;
                        default:      count_q <= count_q;
                    endcase
                end
            end
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.done  = (state == ST_DONE);

`ifdef CNT_COMPARE_EN
    logic cmp_match_q;

    // Registered equality against the compare value.
    always_ff @(posedge CLK) begin
        if (reset) begin
            cmp_match_q <= 1'b0;
        end else begin
            cmp_match_q <= (count_q == bus.cmp_val);
        end
    end

    assign bus.cmp_match = cmp_match_q;
`endif

endmodule

// File: tb/tb_updown_counter_n.sv
// Scoreboard bench for updown_counter_n: two instances (MAX_VAL 15 and 9).
// Stimulus pushes the expected post-edge outputs; a negedge monitor pops and compares.
module tb_updown_counter_n;
    import counter_pkg::*;

    logic clk;
    logic reset;
    int   cyc;
    int   total;
    int   bad;

    typedef struct {
        int         cyc;
        int         dut;
        bit         is_cmp;
        logic [3:0] count;
        logic       tc;
        logic       done;
        logic       cmp;
        string      nm;
    } exp_t;

    exp_t sbq[$];

    updown_counter_n_if #(.WIDTH(4), .PRESC_W(4)) ifa ();
    updown_counter_n_if #(.WIDTH(4), .PRESC_W(4)) ifb ();

    updown_counter_n #(.WIDTH(4), .PRESC_W(4)) dut_a (
        .CLK   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    updown_counter_n #(.WIDTH(4), .MAX_VAL(9), .PRESC_W(4)) dut_b (
        .CLK   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation tagged for the current cycle.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            exp_t       e;
            logic [3:0] ac;
            logic       at;
            logic       ad;
            logic       am;
            e  = sbq.pop_front();
            ac = (e.dut == 0) ? ifa.count : ifb.count;
            at = (e.dut == 0) ? ifa.tc    : ifb.tc;
            ad = (e.dut == 0) ? ifa.done  : ifb.done;
            am = 1'b0;
`ifdef CNT_COMPARE_EN
            am = ifa.cmp_match;
`endif
            total++;
            if (e.cyc < cyc) begin
                bad++;
                $display("FAIL %s: expectation for cycle %0d checked late at cycle %0d", e.nm, e.cyc, cyc);
            end else if (e.is_cmp) begin
                if (am !== e.cmp) begin
                    bad++;
                    $display("FAIL %s: cmp_match=%b required %b", e.nm, am, e.cmp);
                end
            end else if (ac !== e.count || at !== e.tc || ad !== e.done) begin
                bad++;
                $display("FAIL %s: count=%0d tc=%b done=%b required count=%0d tc=%b done=%b",
                         e.nm, ac, at, ad, e.count, e.tc, e.done);
            end
        end
    end

    task automatic ex(input int d, input int c, input bit t, input bit dn, input string nm);
        exp_t e;
        e.cyc = cyc + 1; e.dut = d; e.is_cmp = 1'b0;
        e.count = 4'(c); e.tc = t; e.done = dn; e.cmp = 1'b0; e.nm = nm;
        sbq.push_back(e);
    endtask

    task automatic excmp(input bit m, input string nm);
        exp_t e;
        e.cyc = cyc + 1; e.dut = 0; e.is_cmp = 1'b1;
        e.count = 4'd0; e.tc = 1'b0; e.done = 1'b0; e.cmp = m; e.nm = nm;
        sbq.push_back(e);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int d, input int c, input bit t, input bit dn, input string nm);
        ex(d, c, t, dn, nm);
        nxt();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0; total = 0; bad = 0;
        reset = 1'b1;
        ifa.en = 1'b0; ifa.chnge = 1'b1; ifa.mode = MODE_WRAP; ifa.presc = '0;
        ifa.load_en = 1'b0; ifa.load = '0;
        ifb.en = 1'b0; ifb.chnge = 1'b1; ifb.mode = MODE_WRAP; ifb.presc = '0;
        ifb.load_en = 1'b0; ifb.load = '0;
`ifdef CNT_COMPARE_EN
        ifa.cmp_val = 4'd6;
        ifb.cmp_val = 4'd0;
`endif
        ex(0, 0, 0, 0, "rst_a");
        chk(1, 0, 0, 0, "rst_b");
        reset = 1'b0;

        // Wrap up from 12.
        ifa.load_en = 1'b1; ifa.load = 4'd12; ifa.mode = MODE_WRAP; ifa.chnge = 1'b1; ifa.en = 1'b1;
        chk(0, 12, 0, 0, "wrap_load");
        ifa.load_en = 1'b0;
        chk(0, 13, 0, 0, "wrap_13");
        chk(0, 14, 0, 0, "wrap_14");
        chk(0, 15, 1, 0, "wrap_15_tc");
        chk(0, 0,  0, 0, "wrap_to_0");
        chk(0, 1,  0, 0, "wrap_1");

        // Saturate down from 2.
        ifa.load_en = 1'b1; ifa.load = 4'd2; ifa.mode = MODE_SAT; ifa.chnge = 1'b0;
        chk(0, 2, 0, 0, "satdn_load");
        ifa.load_en = 1'b0;
        chk(0, 1, 0, 0, "satdn_1");
        chk(0, 0, 1, 0, "satdn_0_tc");
        chk(0, 0, 0, 0, "satdn_hold1");
        chk(0, 0, 0, 0, "satdn_hold2");

        // Saturate up at MAX_VAL.
        ifa.load_en = 1'b1; ifa.load = 4'd14; ifa.chnge = 1'b1;
        chk(0, 14, 0, 0, "satup_load");
        ifa.load_en = 1'b0;
        chk(0, 15, 1, 0, "satup_15_tc");
        chk(0, 15, 0, 0, "satup_hold");

        // Switching to one-shot while already on the terminal value.
        ifa.mode = MODE_ONESHOT; ifa.load_en = 1'b1; ifa.load = 4'd15;
        chk(0, 15, 0, 0, "osterm_load");
        ifa.load_en = 1'b0;
        chk(0, 15, 0, 1, "osterm_done");
        chk(0, 15, 0, 1, "osterm_hold");

        // One-shot on the MAX_VAL=9 instance, then reload and clamp.
        ifb.load_en = 1'b1; ifb.load = 4'd7; ifb.mode = MODE_ONESHOT; ifb.chnge = 1'b1; ifb.en = 1'b1;
        chk(1, 7, 0, 0, "os_load");
        ifb.load_en = 1'b0;
        chk(1, 8, 0, 0, "os_8");
        chk(1, 9, 1, 1, "os_9_done");
        chk(1, 9, 0, 1, "os_hold1");
        chk(1, 9, 0, 1, "os_hold2");
        ifb.load_en = 1'b1; ifb.load = 4'd3;
        chk(1, 3, 0, 0, "os_reload");
        ifb.load_en = 1'b0;
        chk(1, 4, 0, 0, "os_4");
        chk(1, 5, 0, 0, "os_5");
        ifb.en = 1'b0; ifb.load_en = 1'b1; ifb.load = 4'd14;
        chk(1, 9, 0, 0, "clamp_14_to_9");
        ifb.load_en = 1'b0;
        chk(1, 9, 0, 0, "clamp_idle");

        // Prescaler: presc=3 gives one step every 4 enabled cycles.
        ifa.mode = MODE_WRAP; ifa.presc = 4'd3; ifa.load_en = 1'b1; ifa.load = 4'd0;
        chk(0, 0, 0, 0, "psc_load");
        ifa.load_en = 1'b0;
        for (int i = 0; i < 3; i++) chk(0, 0, 0, 0, "psc_wait0");
        for (int i = 0; i < 4; i++) chk(0, 1, 0, 0, "psc_step1");
        chk(0, 2, 0, 0, "psc_step2");
        chk(0, 2, 0, 0, "psc_pre_pause1");
        chk(0, 2, 0, 0, "psc_pre_pause2");
        ifa.en = 1'b0;
        for (int i = 0; i < 5; i++) chk(0, 2, 0, 0, "psc_paused");
        ifa.en = 1'b1;
        chk(0, 2, 0, 0, "psc_post_pause");
        chk(0, 3, 0, 0, "psc_extended_step");

        // Direction change mid-count.
        ifa.presc = 4'd0; ifa.load_en = 1'b1; ifa.load = 4'd4;
        chk(0, 4, 0, 0, "dir_load");
        ifa.load_en = 1'b0;
        chk(0, 5, 0, 0, "dir_5");
        ifa.chnge = 1'b0;
        chk(0, 4, 0, 0, "dir_4");
        chk(0, 3, 0, 0, "dir_3");

        // Reset beats a simultaneous load.
        reset = 1'b1; ifa.load_en = 1'b1; ifa.load = 4'd7;
        ex(1, 0, 0, 0, "rst_ld_b");
        chk(0, 0, 0, 0, "rst_ld_a");
        reset = 1'b0; ifa.load_en = 1'b0;

        // Wrap down from 0 to MAX_VAL without a tc pulse.
        chk(0, 15, 0, 0, "wrapdn_15");
        chk(0, 14, 0, 0, "wrapdn_14");

`ifdef CNT_COMPARE_EN
        ifa.chnge = 1'b1; ifa.load_en = 1'b1; ifa.load = 4'd4;
        chk(0, 4, 0, 0, "cmp_load");
        ifa.load_en = 1'b0;
        excmp(1'b0, "cmp_at5");
        chk(0, 5, 0, 0, "cmp_cnt5");
        excmp(1'b0, "cmp_at6");
        chk(0, 6, 0, 0, "cmp_cnt6");
        excmp(1'b1, "cmp_hit");
        chk(0, 7, 0, 0, "cmp_cnt7");
        excmp(1'b0, "cmp_after");
        chk(0, 8, 0, 0, "cmp_cnt8");
`endif

        nxt();
        nxt();
        while (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            total++;
            bad++;
            $display("FAIL %s: never checked, required check at cycle %0d", e.nm, e.cyc);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
